// File: rtl/shift_frame_ctrl_if.sv
// Parallel side of the serial frame engine: transmit word in, captured word out.
// Latency: none (wires only).
// Backpressure: tx_ready throttles the producer, rx_ready acknowledges the consumer.
interface shift_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_ready;

    // Producer/consumer side drives words in and acknowledges captured words
    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data
    );

    // Frame engine side
    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data
    );
endinterface

// File: rtl/shift_frame_ctrl.sv
// Full-duplex serial frame engine: shifts a parallel word out MSB-first while capturing ser_in.
// Latency: WIDTH shift cycles per frame, rx word valid after the last shift edge, period WIDTH+GAP+1.
// Backpressure: one word at a time (no queueing); an unread rx word is overwritten and flags overrun.
module shift_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    shift_frame_ctrl_if.slave   io,
    input  logic                ser_in,
    output logic                ser_out,
    output logic                shift_en,
    output logic                busy,
    output logic                overrun,
    input  logic                clr_overrun
);

    localparam int CW = $clog2(WIDTH);
    // A zero-length gap still needs a legal vector; the counter is simply never used then
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAPS  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             tx_ready_q, tx_ready_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic             frame_done;
    logic [WIDTH-1:0] shifted;

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state: frame sequencing, shift/capture, rx hand-off and overrun tracking
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        // Clear first so that a same-edge set below takes priority
        overrun_d  = overrun_q & ~clr_overrun;
        frame_done = 1'b0;
        accept     = (state_q == IDLE) && io.tx_valid && tx_ready_q;
        shifted    = {sreg_q[WIDTH-2:0], ser_in};

        if (rx_valid_q && io.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = io.tx_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = shifted;
                if (cnt_q == CNT_LAST) begin
                    frame_done = 1'b1;
                    cnt_d      = '0;
                    gap_d      = '0;
                    state_d    = (GAP > 0) ? GAPS : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAPS: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completing frame always publishes; it only counts as overrun if the old word is unread
        if (frame_done) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shifted;
            if (rx_valid_q && !io.rx_ready) begin
                overrun_d = 1'b1;
            end
        end

        // Registered ready: asserted exactly when the engine will be idle next cycle
        tx_ready_d = (state_d == IDLE);
    end

    // Outputs: serial pins are only driven while shifting
    always_comb begin
        shift_en    = (state_q == SHIFT);
        busy        = (state_q != IDLE);
        ser_out     = (state_q == SHIFT) ? sreg_q[WIDTH-1] : 1'b0;
        overrun     = overrun_q;
        io.tx_ready = tx_ready_q;
        io.rx_valid = rx_valid_q;
        io.rx_data  = rx_data_q;
    end

endmodule
